// File: rtl/pac_pkg.sv
// Shared Pac-Man board definitions: board geometry, tile codes and the
// move-committer FSM states.
package pac_pkg;

    localparam int BOARD_W   = 32;
    localparam int BOARD_H   = 24;
    localparam int NUM_CELLS = BOARD_W * BOARD_H;
    localparam int START_LOC = 495;
    localparam int LOC_W     = 10;
    localparam int TILE_W    = 4;

    typedef enum logic [TILE_W-1:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PELLET = 4'd2,
        PAC    = 4'd3
    } tile_t;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        IDLE      = 3'd1,
        WAIT      = 3'd2,
        CHECK     = 3'd3,
        CLEAR_OLD = 3'd4,
        DRAW_NEW  = 3'd5
    } state_t;

endpackage

// File: rtl/move_committer_if.sv
// Move-request handshake plus the board-RAM read/write ports used by
// move_committer.
interface move_committer_if;
    import pac_pkg::*;

    // Request handshake: a request transfers on a rising edge where req_valid
    // and req_ready are both high; req_target must be stable while req_valid
    // is high, and req_ready never depends on req_valid.
    logic              req_valid;
    logic [LOC_W-1:0]  req_target;
    logic              req_ready;

    logic [LOC_W-1:0]  rd_addr;
    logic [TILE_W-1:0] rd_data;

    logic              wr_en;
    logic [LOC_W-1:0]  wr_addr;
    logic [TILE_W-1:0] wr_data;

    // slave: the committer; master: upstream mover together with the board RAM
    modport slave (
        input  req_valid, req_target, rd_data,
        output req_ready, rd_addr, wr_en, wr_addr, wr_data
    );

    modport master (
        output req_valid, req_target, rd_data,
        input  req_ready, rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/move_committer.sv
// Commits Pac-Man moves into the board RAM: read target, reject walls, score
// pellets, erase old tile, draw new tile; tracks location, score, level clear.
module move_committer #(
    parameter int START_LOC     = pac_pkg::START_LOC,
    parameter int NUM_CELLS     = pac_pkg::NUM_CELLS,
    parameter int RD_LAT        = 1,
    parameter int PELLET_PTS    = 10,
    parameter int TOTAL_PELLETS = 200,
    parameter int SCORE_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    move_committer_if.slave            bus,
    output logic [pac_pkg::LOC_W-1:0]  pac_loc,
    output logic [SCORE_W-1:0]         score,
    output logic                       move_done,
    output logic                       move_blocked,
    output logic                       level_clear,
    output pac_pkg::state_t            state
);
    import pac_pkg::*;

    localparam int CNT_W = 2;
    localparam int EAT_W = $clog2(TOTAL_PELLETS + 1);

    logic [LOC_W-1:0]   target;
    logic [LOC_W-1:0]   rd_addr_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [EAT_W-1:0]   eaten;
    logic [EAT_W-1:0]   eaten_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic               req_ready;
    logic               handshake;
    logic               bad_target;
    tile_t              wr_tile;

    assign req_ready  = (state == IDLE) && !level_clear;
    assign handshake  = bus.req_valid && req_ready;
    assign bad_target = (bus.req_target == pac_loc) || (32'(bus.req_target) >= NUM_CELLS);

    // The extra carry bit flags overflow so the score sticks at all-ones.
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(PELLET_PTS);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign eaten_inc = eaten + EAT_W'(1);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            state        <= INIT;
            pac_loc      <= LOC_W'(START_LOC);
            target       <= LOC_W'(START_LOC);
            rd_addr_q    <= LOC_W'(START_LOC);
            wait_cnt     <= '0;
            score        <= '0;
            eaten        <= '0;
            level_clear  <= 1'b0;
            move_blocked <= 1'b0;
        end else begin
            move_blocked <= 1'b0;
            case (state)
                INIT: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (handshake) begin
                        if (bad_target) begin
                            move_blocked <= 1'b1;
                        end else begin
                            target    <= bus.req_target;
                            rd_addr_q <= bus.req_target;
                            wait_cnt  <= CNT_W'(RD_LAT);
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.rd_data == WALL) begin
                        move_blocked <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        if (bus.rd_data == PELLET) begin
                            score <= score_sat;
                            eaten <= eaten_inc;
                            if (eaten_inc == EAT_W'(TOTAL_PELLETS)) begin
                                level_clear <= 1'b1;
                            end
                        end
                        state <= CLEAR_OLD;
                    end
                end
                CLEAR_OLD: begin
                    state <= DRAW_NEW;
                end
                DRAW_NEW: begin
                    pac_loc <= target;
                    state   <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Write port is decoded purely from the state register.
    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        wr_tile     = EMPTY;
        case (state)
            INIT: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = LOC_W'(START_LOC);
                wr_tile     = PAC;
            end
            CLEAR_OLD: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = pac_loc;
                wr_tile     = EMPTY;
            end
            DRAW_NEW: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = target;
                wr_tile     = PAC;
            end
            default: begin
                bus.wr_en   = 1'b0;
                bus.wr_addr = '0;
                wr_tile     = EMPTY;
            end
        endcase
    end

    assign bus.wr_data   = wr_tile;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.req_ready = req_ready;
    assign move_done     = (state == DRAW_NEW);

endmodule

// File: tb/tb_move_committer.sv
// Directed bench for move_committer: one instance with RD_LAT=1 and a large
// pellet budget, one with RD_LAT=2 and TOTAL_PELLETS=2 for level clear.
module tb_move_committer;
  import pac_pkg::*;

  localparam int A_LAT   = 1;
  localparam int A_TOTAL = 7000;
  localparam int B_LAT   = 2;
  localparam int B_TOTAL = 2;
  localparam int PTS     = 10;
  localparam int SMAX    = 65535;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       req_valid;
  logic [9:0] req_target;
  logic       sel;

  move_committer_if a_if ();
  move_committer_if b_if ();

  logic        a_start, b_start;
  logic [9:0]  a_pac, b_pac;
  logic [15:0] a_score, b_score;
  logic        a_done, b_done, a_blk, b_blk, a_lc, b_lc;
  state_t      a_state, b_state;

  assign a_start         = start && !sel;
  assign b_start         = start && sel;
  assign a_if.req_valid  = req_valid && !sel;
  assign b_if.req_valid  = req_valid && sel;
  assign a_if.req_target = req_target;
  assign b_if.req_target = req_target;

  move_committer #(.RD_LAT(A_LAT), .TOTAL_PELLETS(A_TOTAL)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .bus(a_if.slave),
    .pac_loc(a_pac), .score(a_score), .move_done(a_done),
    .move_blocked(a_blk), .level_clear(a_lc), .state(a_state)
  );

  move_committer #(.RD_LAT(B_LAT), .TOTAL_PELLETS(B_TOTAL)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .bus(b_if.slave),
    .pac_loc(b_pac), .score(b_score), .move_done(b_done),
    .move_blocked(b_blk), .level_clear(b_lc), .state(b_state)
  );

  // board RAM model: one shared array, per-instance read latency
  logic [3:0] mem [0:1023];
  logic [3:0] b_pipe;
  always @(posedge clk) begin
    a_if.rd_data <= mem[a_if.rd_addr];
    b_pipe       <= mem[b_if.rd_addr];
    b_if.rd_data <= b_pipe;
  end

  // observation mux onto the instance under test
  logic        obs_ready, obs_done, obs_blk, obs_lc, obs_wr_en;
  logic [9:0]  obs_pac, obs_rd_addr, obs_wr_addr;
  logic [3:0]  obs_wr_data;
  logic [15:0] obs_score;
  assign obs_ready   = sel ? b_if.req_ready : a_if.req_ready;
  assign obs_wr_en   = sel ? b_if.wr_en     : a_if.wr_en;
  assign obs_wr_addr = sel ? b_if.wr_addr   : a_if.wr_addr;
  assign obs_wr_data = sel ? b_if.wr_data   : a_if.wr_data;
  assign obs_rd_addr = sel ? b_if.rd_addr   : a_if.rd_addr;
  assign obs_done    = sel ? b_done  : a_done;
  assign obs_blk     = sel ? b_blk   : a_blk;
  assign obs_lc      = sel ? b_lc    : a_lc;
  assign obs_pac     = sel ? b_pac   : a_pac;
  assign obs_score   = sel ? b_score : a_score;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard of expected RAM writes {addr, data}
  logic [13:0] exp_q[$];
  always @(negedge clk) begin
    if (!reset && !start && obs_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", obs_wr_en, 0);
      end else begin
        check_eq("wr", {obs_wr_addr, obs_wr_data}, exp_q.pop_front());
      end
    end
  end

  // reference model state
  int exp_loc, exp_score, exp_eaten, cur_lat, cur_total;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (obs_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check_eq({tag, "_rdy_in"}, obs_ready, 1);
  endtask

  task automatic do_move(input int tgt, input tile_t tile, input string tag);
    int done_k, blk_k, wr_k, rdy_k;
    int exp_done, exp_blk, exp_wr, exp_rdy;
    bit immediate, accept;
    mem[tgt] = tile;
    immediate = (tgt == exp_loc) || (tgt >= NUM_CELLS);
    accept    = !immediate && (tile != WALL);
    exp_done  = accept ? cur_lat + 3 : 0;
    exp_wr    = accept ? cur_lat + 2 : 0;
    exp_blk   = immediate ? 1 : ((tile == WALL) ? cur_lat + 2 : 0);
    if (accept) begin
      exp_q.push_back({10'(exp_loc), EMPTY});
      exp_q.push_back({10'(tgt), PAC});
      if (tile == PELLET) begin
        exp_score = (exp_score + PTS > SMAX) ? SMAX : exp_score + PTS;
        exp_eaten++;
      end
      exp_loc = tgt;
    end
    if (immediate) exp_rdy = 1;
    else if (tile == WALL) exp_rdy = cur_lat + 2;
    else if (exp_eaten == cur_total) exp_rdy = 0;
    else exp_rdy = cur_lat + 4;

    wait_ready(tag);
    req_target = 10'(tgt);
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    done_k = 0; blk_k = 0; wr_k = 0; rdy_k = 0;
    for (int c = 1; c <= cur_lat + 4; c++) begin
      if (obs_done === 1'b1 && done_k == 0) done_k = c;
      if (obs_blk === 1'b1 && blk_k == 0) blk_k = c;
      if (obs_wr_en === 1'b1 && wr_k == 0) wr_k = c;
      if (obs_ready === 1'b1 && rdy_k == 0) rdy_k = c;
      step();
    end
    check_eq({tag, "_done_cyc"}, done_k, exp_done);
    check_eq({tag, "_blk_cyc"}, blk_k, exp_blk);
    check_eq({tag, "_wr_cyc"}, wr_k, exp_wr);
    check_eq({tag, "_rdy_cyc"}, rdy_k, exp_rdy);
    check_eq({tag, "_pac"}, obs_pac, exp_loc);
    check_eq({tag, "_score"}, obs_score, exp_score);
    check_eq({tag, "_lc"}, obs_lc, (exp_eaten == cur_total) ? 1 : 0);
  endtask

  // pulse start on the selected instance and check the INIT write/outputs
  task automatic restart(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.push_back({10'(START_LOC), PAC});
    exp_loc = START_LOC; exp_score = 0; exp_eaten = 0;
    check_eq({tag, "_init_rdy"}, obs_ready, 0);
    check_eq({tag, "_init_pac"}, obs_pac, START_LOC);
    check_eq({tag, "_init_score"}, obs_score, 0);
    check_eq({tag, "_init_lc"}, obs_lc, 0);
    check_eq({tag, "_init_rd_addr"}, obs_rd_addr, START_LOC);
    step();
    check_eq({tag, "_idle_rdy"}, obs_ready, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_target = '0; sel = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = EMPTY;
    cur_lat = A_LAT; cur_total = A_TOTAL;
    exp_loc = START_LOC; exp_score = 0; exp_eaten = 0;

    // reset then idle
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back({10'(START_LOC), PAC});
    reset = 1'b0;
    check_eq("rst_rdy", obs_ready, 0);
    check_eq("rst_pac", obs_pac, START_LOC);
    check_eq("rst_score", obs_score, 0);
    check_eq("rst_done", obs_done, 0);
    check_eq("rst_blk", obs_blk, 0);
    check_eq("rst_lc", obs_lc, 0);
    check_eq("rst_rd_addr", obs_rd_addr, START_LOC);
    step();
    check_eq("idle_rdy", obs_ready, 1);

    // immediate rejects, then ordinary moves
    do_move(495, EMPTY, "same_cell");
    do_move(768, EMPTY, "oob_768");
    do_move(1023, EMPTY, "oob_1023");
    do_move(496, EMPTY, "mv_empty");
    do_move(497, PELLET, "mv_pellet");
    do_move(498, WALL, "mv_wall");
    do_move(497, EMPTY, "same_cell2");

    // start while the move is in WAIT: the move is abandoned
    wait_ready("abort");
    mem[0] = EMPTY;
    req_target = 10'd0;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    check_eq("abort_in_wait_rd_addr", obs_rd_addr, 0);
    restart("abort");

    // last valid cell, then score saturation at 65535
    do_move(767, EMPTY, "mv_last_cell");
    for (int i = 0; i < 6554; i++) begin
      do_move((i % 2 == 0) ? 100 : 101, PELLET, "sat");
    end
    check_eq("sat_final", obs_score, SMAX);
    check_eq("sat_no_lc", obs_lc, 0);

    // level clear on the second instance
    sel = 1'b1;
    cur_lat = B_LAT; cur_total = B_TOTAL;
    step();
    restart("b");
    do_move(200, PELLET, "lc1");
    do_move(201, PELLET, "lc2");
    mem[202] = EMPTY;
    req_target = 10'd202;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("lc_hold_rdy", obs_ready, 0);
      check_eq("lc_hold_done", obs_done, 0);
    end
    req_valid = 1'b0;
    check_eq("lc_hold_lc", obs_lc, 1);
    check_eq("lc_hold_pac", obs_pac, 201);
    check_eq("lc_hold_score", obs_score, 20);
    restart("b_again");

    repeat (2) step();
    check_eq("wr_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_committer.md
# move_committer

Commits Pac-Man moves into the game-board RAM. Sits between `pac_man_behavior` (upstream, which proposes a target block) and the board RAM (downstream), replacing the ad-hoc idle/clear_old/draw_pac/update sequence in the top level. For each requested move it reads the target block, rejects walls, scores pellets, then erases the old Pac-Man tile and draws the new one. It also tracks Pac-Man's location, score and level completion.

## Interface
Parameters:
- `START_LOC`, 495: block index where Pac-Man is placed on reset/start.
- `NUM_CELLS`, 768: board size (32×24); valid addresses are 0..NUM_CELLS-1.
- `RD_LAT`, 1: cycles from a change on `rd_addr` until `rd_data` reflects it (1..3).
- `PELLET_PTS`, 10: score increment per pellet.
- `TOTAL_PELLETS`, 200: pellets on a full board.
- `SCORE_W`, 16: score width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: restart the game; same effect as `reset`.
- `req_valid` in 1: move request present.
- `req_target` in 10: requested block index.
- `req_ready` out 1: block accepts a request this cycle.
- `rd_addr` out 10: board RAM read address on a dedicated read port.
- `rd_data` in 4: board RAM read data.
- `wr_en` out 1: board RAM write enable.
- `wr_addr` out 10: board RAM write address.
- `wr_data` out 4: board RAM write data.
- `pac_loc` out 10: current Pac-Man block.
- `score` out SCORE_W: accumulated score.
- `move_done` out 1: one-cycle pulse when a move is committed.
- `move_blocked` out 1: one-cycle pulse when a request is rejected.
- `level_clear` out 1: high when all pellets have been eaten.

## Operation
- Tile codes (4-bit): EMPTY=0, WALL=1, PELLET=2, PAC=3.
- FSM states: INIT, IDLE, WAIT, CHECK, CLEAR_OLD, DRAW_NEW.
- **INIT** (entered on reset/start)
  - Drives `wr_en`=1, `wr_addr`=START_LOC, `wr_data`=PAC.
  - Next state is IDLE.
- **IDLE**
  - `req_ready`=1 unless `level_clear` is high.
  - On handshake, if `req_target` equals `pac_loc` or is ≥ NUM_CELLS: pulse `move_blocked` next cycle and stay in IDLE.
  - Otherwise latch the target, set `rd_addr` to the target, load the wait counter with RD_LAT, and go to WAIT.
- **WAIT**
  - Decrement the counter; go to CHECK when it reaches 0.
  - `rd_addr` is held at the target throughout.
- **CHECK**: sample `rd_data`.
  - WALL: pulse `move_blocked` and go to IDLE.
  - PELLET: score += PELLET_PTS, saturating at 2^SCORE_W−1; increment the eaten count.
  - Any non-WALL code: go to CLEAR_OLD.
- **CLEAR_OLD**: `wr_en`=1, `wr_addr`=`pac_loc`, `wr_data`=EMPTY.
- **DRAW_NEW**
  - `wr_en`=1, `wr_addr`=target, `wr_data`=PAC.
  - `pac_loc` ← target; pulse `move_done`; go to IDLE.
- `level_clear` = (eaten count == TOTAL_PELLETS). It is sticky until reset/start, and requests stay unaccepted (`req_ready`=0) while it is high.

## Timing
- All outputs are registered or decoded from the state register only. None depend combinationally on `req_valid` or `rd_data`.
- Reset/start (priority over everything, including mid-move) produces these values on the following cycle:
  - state INIT, `pac_loc`=START_LOC, `score`=0, eaten=0;
  - `req_ready`=0, `move_done`=0, `move_blocked`=0, `level_clear`=0;
  - `rd_addr`=START_LOC.
- A move in flight when reset/start arrives is abandoned; no CLEAR_OLD/DRAW_NEW write is issued for it.
- A handshake at cycle T gives:
  - WAIT during T+1..T+RD_LAT; CHECK at T+RD_LAT+1;
  - CLEAR_OLD write at T+RD_LAT+2; DRAW_NEW write and `move_done` at T+RD_LAT+3;
  - `req_ready` again at T+RD_LAT+4.
- Rejections:
  - A wall reject pulses `move_blocked` at T+RD_LAT+2.
  - An out-of-range or same-cell reject pulses `move_blocked` at T+1, with `req_ready` high again at T+1.
- `wr_en` is high for exactly one cycle in each of INIT, CLEAR_OLD and DRAW_NEW, and low everywhere else.
- `score` and `pac_loc` update on the edge that leaves CHECK and DRAW_NEW respectively.

## Structure
- Shared package `pac_pkg`:
  - `tile_t` enum (EMPTY, WALL, PELLET, PAC);
  - BOARD_W=32, BOARD_H=24, NUM_CELLS, START_LOC;
  - `state_t` for this FSM.
- The top level uses the package codes in place of the literal 4'b0011/4'b0000.
- Single module. The saturating score counter is inline; no sub-module is warranted.
- Board RAM provides a second read port (or a time-multiplexed port) reserved for `rd_addr`. The video path keeps its own port.

## Test plan
- Reset then idle: one write of (495, PAC) in INIT; afterwards `pac_loc`=495, `score`=0, `req_ready`=1.
- Request 496 with the RAM model returning EMPTY (RD_LAT=1):
  - writes (495, EMPTY) at T+3 and (496, PAC) at T+4;
  - `move_done` at T+4; `pac_loc`=496.
- Request onto a PELLET: `score` 0→10, eaten 1, both writes occur. Repeat to 6554 pellets with SCORE_W=16: `score` saturates at 65535.
- Request onto a WALL: `move_blocked` at T+3, no `wr_en`, `pac_loc` unchanged. Request 768 or 495: `move_blocked` at T+1.
- Assert `start` while in WAIT: no CLEAR_OLD/DRAW_NEW writes; next cycle INIT writes (495, PAC) and `score` resets to 0.
- TOTAL_PELLETS=2 and two pellet moves: `level_clear`=1 after the second DRAW_NEW; `req_ready` stays 0 while `req_valid` is held high.
